hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 129 ++++++++++++
 tb/tb_hilo_muldiv.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: single-cycle MTHI/MTLO moves, WIDTH-cycle bit-serial
// shift-add multiply and restoring divide, results committed to HI/LO in FINISH.
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  localparam logic [2:0] OpMthi  = 3'd1;
  localparam logic [2:0] OpMtlo  = 3'd2;
  localparam logic [2:0] OpMult  = 3'd3;
  localparam logic [2:0] OpMultu = 3'd4;
  localparam logic [2:0] OpDiv   = 3'd5;
  localparam logic [2:0] OpDivu  = 3'd6;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;
  logic             r_is_div, r_div0, r_sign_q, r_sign_r;
  logic [WIDTH-1:0] r_b, r_rem, r_quo;
  logic [CW-1:0]    r_count;

  logic             w_accept, w_is_muldiv, w_signed_op, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_add, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod_res;
  logic [WIDTH-1:0] w_quo_res, w_rem_res;

  assign w_is_muldiv = (operation == OpMult) || (operation == OpMultu) ||
                       (operation == OpDiv)  || (operation == OpDivu);
  assign w_signed_op = (operation == OpMult) || (operation == OpDiv);
  assign w_accept    = start && !cancel && (r_state == StIdle);

  assign w_a_neg = w_signed_op && operand_a[WIDTH-1];
  assign w_b_neg = w_signed_op && operand_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag = w_b_neg ? -operand_b : operand_b;

  // Multiply: r_rem:r_quo is the running product, multiplier bits consumed from r_quo[0].
  assign w_add   = {1'b0, r_rem} + {1'b0, (r_quo[0] ? r_b : '0)};
  // Divide: r_rem is the partial remainder, dividend bits shifted in from r_quo MSB.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  assign w_prod_res = r_sign_q ? -{r_rem, r_quo} : {r_rem, r_quo};
  assign w_quo_res  = r_sign_q ? -r_quo : r_quo;
  assign w_rem_res  = r_sign_r ? -r_rem : r_rem;

  always_comb begin
    w_state_next = r_state;
    if (cancel) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:   if (start && w_is_muldiv) w_state_next = StRun;
        StRun:    if (r_count == LastCount) w_state_next = StFinish;
        StFinish: w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (w_accept && operation == OpMthi) r_hi <= operand_a;
      if (w_accept && operation == OpMtlo) r_lo <= operand_a;
      if (r_state == StFinish && !cancel) begin
        r_done <= 1'b1;
        if (!r_is_div) begin
          {r_hi, r_lo} <= w_prod_res;
        end else if (!r_div0) begin
          r_hi <= w_rem_res;
          r_lo <= w_quo_res;
        end
      end
    end
  end

  // Datapath carries no reset: it is always reloaded on the accepting edge.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_muldiv) begin
      r_is_div <= (operation == OpDiv) || (operation == OpDivu);
      r_div0   <= (operand_b == '0);
      r_sign_q <= w_a_neg ^ w_b_neg;
      r_sign_r <= w_a_neg;
      r_b      <= w_b_mag;
      r_rem    <= '0;
      r_quo    <= w_a_mag;
      r_count  <= '0;
    end else if (r_state == StRun) begin
      r_count <= r_count + 1'b1;
      if (!r_is_div) begin
        r_rem <= w_add[WIDTH:1];
        r_quo <= {w_add[0], r_quo[WIDTH-1:1]};
      end else begin
        r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
      end
    end
  end

  assign busy = (r_state != StIdle);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv (WIDTH=32): directed vectors, random ops against a
// behavioural model, cancel and reset-in-flight scenarios.
module tb_hilo_muldiv;

  localparam int W = 32;
  localparam logic [2:0] Nop = 3'd0, Mthi = 3'd1, Mtlo = 3'd2, Mult = 3'd3;
  localparam logic [2:0] Multu = 3'd4, Div = 3'd5, Divu = 3'd6, Rsvd = 3'd7;

  logic         clock = 1'b0;
  logic         reset, start, cancel;
  logic [2:0]   operation;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] m_hi, m_lo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] h,
                                        input logic [W-1:0] l);
    longint sa, sb_v, q, r;
    logic [63:0] res;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    res  = {h, l};
    case (op)
      Mult:  res = sa * sb_v;
      Multu: res = {32'b0, a} * {32'b0, b};
      Div:   if (b != 0) begin
               q = sa / sb_v;
               r = sa % sb_v;
               res = {r[31:0], q[31:0]};
             end
      Divu:  if (b != 0) res = {a % b, a / b};
      default: res = {h, l};
    endcase
    return res;
  endfunction

  // Caller is at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    operation = op;
    operand_a = a;
    operand_b = b;
    @(negedge clock);
    start = 1'b0;
    operation = Nop;
    operand_a = '0;
    operand_b = '0;
  endtask

  task automatic wait_done(input string tag);
    int   e = 0;
    logic busy_ok = 1'b1;
    exp_t x;
    while (!done && e < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clock);
      e++;
    end
    check_eq({tag, "_latency"}, e, 33);
    check_eq({tag, "_busy_run"}, busy_ok, 1);
    check_eq({tag, "_busy_after"}, busy, 0);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 0, 1);
    end else begin
      x = sb.pop_front();
      check_eq({tag, "_hi"}, hi, x.hi);
      check_eq({tag, "_lo"}, lo, x.lo);
    end
  endtask

  task automatic do_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input string tag);
    exp_t x;
    x.hi = ehi;
    x.lo = elo;
    sb.push_back(x);
    m_hi = ehi;
    m_lo = elo;
    issue(op, a, b);
    wait_done(tag);
  endtask

  task automatic do_rand(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
    logic [63:0] r;
    r = model(op, a, b, m_hi, m_lo);
    do_md(op, a, b, r[63:32], r[31:0], tag);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    operation = Nop;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);

    issue(Mthi, 32'hFFFF0000, 32'h0);
    check_eq("mthi_hi", hi, 32'hFFFF0000);
    check_eq("mthi_lo", lo, 0);
    check_eq("mthi_busy", busy, 0);
    issue(Mtlo, 32'h05050000, 32'h0);
    check_eq("mtlo_lo", lo, 32'h05050000);
    check_eq("mtlo_hi", hi, 32'hFFFF0000);
    check_eq("mtlo_busy", busy, 0);
    check_eq("mtlo_done", done, 0);
    m_hi = 32'hFFFF0000;
    m_lo = 32'h05050000;

    issue(Nop, 32'h1111, 32'h2222);
    issue(Rsvd, 32'h3333, 32'h4444);
    check_eq("nop_hilo", {hi, lo}, {m_hi, m_lo});
    check_eq("nop_busy", {busy, done}, 0);

    cancel = 1'b1;
    issue(Mthi, 32'h1234, 32'h0);
    cancel = 1'b0;
    check_eq("cancel_idle_hi", hi, m_hi);

    do_md(Mult, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    do_md(Multu, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, "multu_b2b");
    @(negedge clock);
    check_eq("done_width", done, 0);
    do_md(Div, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    do_md(Div, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf");
    do_md(Divu, 32'h12345678, 32'h0, m_hi, m_lo, "divu_zero");

    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = 3'(Mult + (i % 4));
      do_rand(op, $urandom, (i == 6) ? 32'h0 : ((i % 2) ? $urandom : $urandom_range(1, 999)),
              $sformatf("rand%0d", i));
    end

    // Cancel mid-MULTU, with a start presented while busy.
    issue(Multu, 32'hABCD1234, 32'h5678);
    for (int i = 1; i < 10; i++) begin
      if (i == 5) begin
        start = 1'b1;
        operation = Mthi;
        operand_a = 32'hDEADBEEF;
      end
      @(negedge clock);
      start = 1'b0;
      operation = Nop;
    end
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check_eq("cancel_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clock);
    end
    check_eq("cancel_no_done", seen, 0);
    check_eq("cancel_hi", hi, m_hi);
    check_eq("cancel_lo", lo, m_lo);

    // Reset in the middle of a DIV.
    issue(Div, 32'd100, 32'd7);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("rstmid_hilo", {hi, lo}, 0);
    check_eq("rstmid_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clock);
    end
    check_eq("rstmid_no_done", seen, 0);
    issue(Mtlo, 32'h1, 32'h0);
    check_eq("post_rst_lo", lo, 1);
    check_eq("post_rst_hi", hi, 0);
    check_eq("post_rst_busy", busy, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
